// File: rtl/udp_transmit_handler_if.sv
// Bundle of the TX FIFO read side and the UDP encoder request/stream side.
// master: the transmit handler (pops the FIFO, drives request and payload).
// slave : the environment (FIFO head word, grant, payload ready).
interface udp_transmit_handler_if;
    // virtual-port TX FIFO, first-word-fall-through, {marker, byte}
    logic [8:0]  fifo_data;
    logic        fifo_valid;
    logic        fifo_read;
    // encoder frame request
    logic        tx_request;
    logic        tx_grant;
    logic [15:0] tx_udp_destination;
    logic [15:0] tx_udp_length;
    // encoder payload stream
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_data_ready;
    logic        tx_data_last;
    logic        tx_abort;

    modport master (
        input  fifo_data, fifo_valid, tx_grant, tx_data_ready,
        output fifo_read, tx_request, tx_udp_destination, tx_udp_length,
               tx_data, tx_data_valid, tx_data_last, tx_abort
    );

    modport slave (
        output fifo_data, fifo_valid, tx_grant, tx_data_ready,
        input  fifo_read, tx_request, tx_udp_destination, tx_udp_length,
               tx_data, tx_data_valid, tx_data_last, tx_abort
    );
endinterface

// File: rtl/udp_transmit_handler.sv
// Purpose: parses framed words from the TX FIFO and streams one UDP payload per frame to the encoder.
// Latency: 4 header pops then a request; first payload byte valid 1 cycle after grant; 1 byte/clock.
// Backpressure: single output register, refilled only when empty or accepted; FIFO underrun stalls.
//
// Ports:
//   clock, reset_n       clock and synchronous active-low reset
//   enable               0 blocks the start of a new frame (sampled only while idle)
//   bus (master)         FIFO head/pop, encoder request/grant, payload valid/ready/last, tx_abort
//   frame_done           1-cycle pulse when the last payload byte is accepted
//   frame_error          1-cycle pulse on a framing or length error (frame dropped)
//   busy                 high whenever the parser is not idle
module udp_transmit_handler #(
    parameter int MAX_PAYLOAD_BYTES = 1472,
    parameter int UDP_HEADER_BYTES  = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    udp_transmit_handler_if.master bus,
    output logic                   frame_done,
    output logic                   frame_error,
    output logic                   busy
);
    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD_BYTES);
    localparam logic [15:0] HDR_LEN = 16'(UDP_HEADER_BYTES);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_DEST_LSB = 3'd1;
    localparam logic [2:0] S_LEN_MSB  = 3'd2;
    localparam logic [2:0] S_LEN_LSB  = 3'd3;
    localparam logic [2:0] S_REQUEST  = 3'd4;
    localparam logic [2:0] S_STREAM   = 3'd5;
    localparam logic [2:0] S_DRAIN    = 3'd6;

    logic [2:0]  state;
    logic [7:0]  dst_msb;
    logic [7:0]  dst_lsb;
    logic [7:0]  len_msb;
    logic [15:0] remaining;

    logic        head_marker;
    logic [7:0]  head_byte;
    logic [15:0] len_word;
    logic        load;
    logic        stream_abort;

    assign head_marker = bus.fifo_data[8];
    assign head_byte   = bus.fifo_data[7:0];
    assign len_word    = {len_msb, head_byte};
    // output register may take a new byte when it is empty or being accepted
    assign load        = !bus.tx_data_valid || bus.tx_data_ready;
    // a start-of-frame marker before the payload is complete truncates the frame;
    // the marker word is left in the FIFO so the next frame parses from it
    assign stream_abort = (state == S_STREAM) && bus.fifo_valid && head_marker && (remaining != 16'd0);
    assign busy         = (state != S_IDLE);

    always_comb begin
        bus.fifo_read = 1'b0;
        if (reset_n) begin
            case (state)
                S_IDLE:                           bus.fifo_read = bus.fifo_valid && enable;
                S_DEST_LSB, S_LEN_MSB, S_LEN_LSB: bus.fifo_read = bus.fifo_valid;
                S_STREAM: bus.fifo_read = load && bus.fifo_valid && !head_marker && (remaining != 16'd0);
                S_DRAIN:  bus.fifo_read = bus.fifo_valid && !head_marker && (remaining != 16'd0);
                default:  bus.fifo_read = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state                  <= S_IDLE;
            dst_msb                <= 8'd0;
            dst_lsb                <= 8'd0;
            len_msb                <= 8'd0;
            remaining              <= 16'd0;
            bus.tx_request         <= 1'b0;
            bus.tx_udp_destination <= 16'd0;
            bus.tx_udp_length      <= 16'd0;
            bus.tx_data            <= 8'd0;
            bus.tx_data_valid      <= 1'b0;
            bus.tx_data_last       <= 1'b0;
            bus.tx_abort           <= 1'b0;
            frame_done             <= 1'b0;
            frame_error            <= 1'b0;
        end else begin
            frame_done   <= 1'b0;
            frame_error  <= 1'b0;
            bus.tx_abort <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.fifo_read) begin
                        if (head_marker) begin
                            dst_msb <= head_byte;
                            state   <= S_DEST_LSB;
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end
                end
                S_DEST_LSB, S_LEN_MSB, S_LEN_LSB: begin
                    if (bus.fifo_read) begin
                        if (head_marker) begin
                            // unexpected start of frame: resync on it
                            frame_error <= 1'b1;
                            dst_msb     <= head_byte;
                            state       <= S_DEST_LSB;
                        end else if (state == S_DEST_LSB) begin
                            dst_lsb <= head_byte;
                            state   <= S_LEN_MSB;
                        end else if (state == S_LEN_MSB) begin
                            len_msb <= head_byte;
                            state   <= S_LEN_LSB;
                        end else if (len_word == 16'd0) begin
                            frame_error <= 1'b1;
                            state       <= S_IDLE;
                        end else if (len_word > MAX_LEN) begin
                            frame_error <= 1'b1;
                            remaining   <= len_word;
                            state       <= S_DRAIN;
                        end else begin
                            bus.tx_udp_destination <= {dst_msb, dst_lsb};
                            bus.tx_udp_length      <= len_word + HDR_LEN;
                            bus.tx_request         <= 1'b1;
                            remaining              <= len_word;
                            state                  <= S_REQUEST;
                        end
                    end
                end
                S_REQUEST: begin
                    if (bus.tx_grant) begin
                        bus.tx_request <= 1'b0;
                        state          <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (stream_abort) begin
                        bus.tx_abort      <= 1'b1;
                        frame_error       <= 1'b1;
                        bus.tx_data_valid <= 1'b0;
                        bus.tx_data_last  <= 1'b0;
                        state             <= S_IDLE;
                    end else begin
                        if (bus.tx_data_valid && bus.tx_data_ready && bus.tx_data_last) begin
                            frame_done <= 1'b1;
                            state      <= S_IDLE;
                        end
                        if (bus.fifo_read) begin
                            bus.tx_data       <= head_byte;
                            bus.tx_data_valid <= 1'b1;
                            bus.tx_data_last  <= (remaining == 16'd1);
                            remaining         <= remaining - 16'd1;
                        end else if (load) begin
                            bus.tx_data_valid <= 1'b0;
                            bus.tx_data_last  <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (bus.fifo_read) begin
                        remaining <= remaining - 16'd1;
                    end else if ((remaining == 16'd0) || (bus.fifo_valid && head_marker)) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_udp_transmit_handler.sv
module tb_udp_transmit_handler;
    logic clock;
    logic reset_n;
    logic enable;
    logic frame_done;
    logic frame_error;
    logic busy;

    udp_transmit_handler_if bus();

    udp_transmit_handler #(
        .MAX_PAYLOAD_BYTES(1472),
        .UDP_HEADER_BYTES (8)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .bus        (bus),
        .frame_done (frame_done),
        .frame_error(frame_error),
        .busy       (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // FIFO model and monitor state, all owned by the main process
    logic [8:0]  q[$];
    logic [8:0]  rx_log[0:4095];
    int          acc_cyc[0:4095];
    int          rx_cnt, pops, cycle;
    int          done_cnt, err_cnt, abort_cnt, req_frames, req_cycles, stall_viol;
    logic [15:0] last_dst, last_len;
    logic        prev_req, prev_stall, pop_pending;
    logic [8:0]  prev_out;
    int          grant_delay, req_age;
    bit          ready_toggle;
    int          n_checks, n_fail;
    int          b_rx, b_pops, b_done, b_err, b_abort, b_reqf, b_reqc, b_stall;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic refresh_fifo();
        if (q.size() != 0) begin
            bus.fifo_valid = 1'b1;
            bus.fifo_data  = q[0];
        end else begin
            bus.fifo_valid = 1'b0;
            bus.fifo_data  = 9'h000;
        end
    endtask

    // one clock: sample the pop strobe before the edge, update inputs after it, observe at negedge
    task automatic step();
        #1;
        pop_pending = bus.fifo_read;
        @(posedge clock);
        if (pop_pending && q.size() > 0) begin
            void'(q.pop_front());
            pops++;
        end
        #1;
        if (bus.tx_request) begin
            if (req_age >= grant_delay) bus.tx_grant = 1'b1;
            req_age++;
        end else begin
            bus.tx_grant = 1'b0;
            req_age      = 0;
        end
        bus.tx_data_ready = ready_toggle ? ~bus.tx_data_ready : 1'b1;
        refresh_fifo();
        @(negedge clock);
        cycle++;
        if (reset_n) begin
            if (bus.tx_data_valid && bus.tx_data_ready) begin
                rx_log[rx_cnt]  = {bus.tx_data_last, bus.tx_data};
                acc_cyc[rx_cnt] = cycle;
                rx_cnt++;
            end
            if (prev_stall && (!bus.tx_data_valid || {bus.tx_data_last, bus.tx_data} != prev_out))
                stall_viol++;
            prev_stall = bus.tx_data_valid && !bus.tx_data_ready;
            prev_out   = {bus.tx_data_last, bus.tx_data};
            done_cnt  += int'(frame_done);
            err_cnt   += int'(frame_error);
            abort_cnt += int'(bus.tx_abort);
            if (bus.tx_request) begin
                req_cycles++;
                if (!prev_req) begin
                    req_frames++;
                    last_dst = bus.tx_udp_destination;
                    last_len = bus.tx_udp_length;
                end
            end
            prev_req = bus.tx_request;
        end
    endtask

    task automatic push_hdr(input logic [15:0] dst, input logic [15:0] len);
        q.push_back({1'b1, dst[15:8]});
        q.push_back({1'b0, dst[7:0]});
        q.push_back({1'b0, len[15:8]});
        q.push_back({1'b0, len[7:0]});
    endtask

    task automatic push_byte(input logic [7:0] b);
        q.push_back({1'b0, b});
    endtask

    task automatic snap();
        b_rx = rx_cnt; b_pops = pops; b_done = done_cnt; b_err = err_cnt;
        b_abort = abort_cnt; b_reqf = req_frames; b_reqc = req_cycles; b_stall = stall_viol;
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while (!(q.size() == 0 && !bus.fifo_valid && !busy && !bus.tx_data_valid) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) chk("idle_timeout", 32'd0, 32'd1);
        repeat (3) step();
    endtask

    initial begin
        int bad;
        int lasts;
        reset_n = 1'b0; enable = 1'b1;
        bus.fifo_data = 9'h000; bus.fifo_valid = 1'b0;
        bus.tx_grant = 1'b0; bus.tx_data_ready = 1'b1;
        rx_cnt = 0; pops = 0; cycle = 0; done_cnt = 0; err_cnt = 0; abort_cnt = 0;
        req_frames = 0; req_cycles = 0; stall_viol = 0; last_dst = 16'h0; last_len = 16'h0;
        prev_req = 1'b0; prev_stall = 1'b0; pop_pending = 1'b0; prev_out = 9'h0;
        grant_delay = 2; req_age = 0; ready_toggle = 1'b0; n_checks = 0; n_fail = 0;

        // reset with a frame already waiting: nothing may be popped
        snap();
        push_hdr(16'h1234, 16'd3); push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC);
        repeat (3) step();
        chk("rst_fifo_read", 32'(bus.fifo_read), 32'd0);
        chk("rst_tx_request", 32'(bus.tx_request), 32'd0);
        chk("rst_tx_data_valid", 32'(bus.tx_data_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_udp_length", 32'(bus.tx_udp_length), 32'd0);
        chk("rst_pulses", {29'd0, frame_done, frame_error, bus.tx_abort}, 32'd0);
        chk("rst_no_pop", 32'(pops - b_pops), 32'd0);

        // 1: basic frame, grant after 2 cycles, ready held high
        reset_n = 1'b1;
        run_until_idle(200);
        chk("t1_rx_count", 32'(rx_cnt - b_rx), 32'd3);
        chk("t1_byte0", 32'(rx_log[b_rx]), 32'h0AA);
        chk("t1_byte1", 32'(rx_log[b_rx+1]), 32'h0BB);
        chk("t1_byte2_last", 32'(rx_log[b_rx+2]), 32'h1CC);
        chk("t1_back_to_back", 32'(acc_cyc[b_rx+2] - acc_cyc[b_rx]), 32'd2);
        chk("t1_dst", 32'(last_dst), 32'h1234);
        chk("t1_length", 32'(last_len), 32'd11);
        chk("t1_req_cycles", 32'(req_cycles - b_reqc), 32'd3);
        chk("t1_done", 32'(done_cnt - b_done), 32'd1);
        chk("t1_err", 32'(err_cnt - b_err), 32'd0);

        // 2: same frame with ready toggling
        snap();
        ready_toggle = 1'b1;
        push_hdr(16'h1234, 16'd3); push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC);
        run_until_idle(200);
        ready_toggle = 1'b0;
        chk("t2_rx_count", 32'(rx_cnt - b_rx), 32'd3);
        chk("t2_bytes", {5'd0, rx_log[b_rx], rx_log[b_rx+1], rx_log[b_rx+2]}, {5'd0, 9'h0AA, 9'h0BB, 9'h1CC});
        chk("t2_stall_hold", 32'(stall_viol - b_stall), 32'd0);
        chk("t2_pops", 32'(pops - b_pops), 32'd7);
        chk("t2_done", 32'(done_cnt - b_done), 32'd1);

        // 3: truncated frame followed by a good one
        snap();
        push_hdr(16'h0102, 16'd5); push_byte(8'h01); push_byte(8'h02);
        push_hdr(16'h0A0B, 16'd2); push_byte(8'h5A); push_byte(8'h5B);
        run_until_idle(200);
        chk("t3_abort", 32'(abort_cnt - b_abort), 32'd1);
        chk("t3_err", 32'(err_cnt - b_err), 32'd1);
        chk("t3_req_frames", 32'(req_frames - b_reqf), 32'd2);
        chk("t3_rx_count", 32'(rx_cnt - b_rx), 32'd4);
        chk("t3_bytes", {14'd0, rx_log[b_rx+2], rx_log[b_rx+3]}, {14'd0, 9'h05A, 9'h15B});
        chk("t3_dst2", 32'(last_dst), 32'h0A0B);
        chk("t3_length2", 32'(last_len), 32'd10);
        chk("t3_done", 32'(done_cnt - b_done), 32'd1);

        // 4: oversize length is drained, next frame is sent
        snap();
        push_hdr(16'h5555, 16'h05C1);
        for (int i = 0; i < 1473; i++) push_byte(8'h00);
        push_hdr(16'h0203, 16'd1); push_byte(8'h77);
        run_until_idle(3000);
        chk("t4_err", 32'(err_cnt - b_err), 32'd1);
        chk("t4_req_frames", 32'(req_frames - b_reqf), 32'd1);
        chk("t4_dst", 32'(last_dst), 32'h0203);
        chk("t4_pops", 32'(pops - b_pops), 32'd1482);
        chk("t4_rx", 32'(rx_log[b_rx]), 32'h177);
        chk("t4_rx_count", 32'(rx_cnt - b_rx), 32'd1);

        // 4b: exactly the maximum length is streamed
        snap();
        push_hdr(16'hBEEF, 16'h05C0);
        for (int i = 0; i < 1472; i++) push_byte(8'(i));
        run_until_idle(3000);
        bad = 0; lasts = 0;
        for (int i = 0; i < 1472; i++) begin
            if (rx_log[b_rx+i] !== {1'(i == 1471), 8'(i)}) bad++;
            if (rx_log[b_rx+i][8]) lasts++;
        end
        chk("t4b_length", 32'(last_len), 32'd1480);
        chk("t4b_rx_count", 32'(rx_cnt - b_rx), 32'd1472);
        chk("t4b_payload", 32'(bad), 32'd0);
        chk("t4b_single_last", 32'(lasts), 32'd1);
        chk("t4b_err", 32'(err_cnt - b_err), 32'd0);

        // 5: enable=0 holds off parsing; stray word and len=0 frame are errors
        snap();
        enable = 1'b0;
        push_byte(8'h55);
        repeat (5) step();
        chk("t5_disabled_pops", 32'(pops - b_pops), 32'd0);
        chk("t5_disabled_busy", 32'(busy), 32'd0);
        enable = 1'b1;
        push_hdr(16'h0304, 16'd0);
        push_hdr(16'h0405, 16'd1); push_byte(8'h99);
        run_until_idle(200);
        chk("t5_err", 32'(err_cnt - b_err), 32'd2);
        chk("t5_req_frames", 32'(req_frames - b_reqf), 32'd1);
        chk("t5_pops", 32'(pops - b_pops), 32'd10);
        chk("t5_rx", 32'(rx_log[b_rx]), 32'h199);

        // 6: reset mid-stream, then a clean frame
        snap();
        push_hdr(16'h0607, 16'd4);
        push_byte(8'h10); push_byte(8'h20); push_byte(8'h30); push_byte(8'h40);
        begin
            int n;
            n = 0;
            while ((rx_cnt - b_rx) < 2 && n < 100) begin
                step();
                n++;
            end
            if (n >= 100) chk("t6_stream_timeout", 32'd0, 32'd1);
        end
        reset_n = 1'b0;
        q.delete();
        refresh_fifo();
        step();
        chk("t6_rst_valid", 32'(bus.tx_data_valid), 32'd0);
        chk("t6_rst_data", {23'd0, bus.tx_data_last, bus.tx_data}, 32'd0);
        chk("t6_rst_request", 32'(bus.tx_request), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_fifo_read", 32'(bus.fifo_read), 32'd0);
        chk("t6_rst_pulses", {29'd0, frame_done, frame_error, bus.tx_abort}, 32'd0);
        chk("t6_rst_dst", 32'(bus.tx_udp_destination), 32'd0);
        reset_n = 1'b1;
        snap();
        push_hdr(16'h0809, 16'd2); push_byte(8'hE1); push_byte(8'hE2);
        run_until_idle(200);
        chk("t6_rx_count", 32'(rx_cnt - b_rx), 32'd2);
        chk("t6_bytes", {14'd0, rx_log[b_rx], rx_log[b_rx+1]}, {14'd0, 9'h0E1, 9'h1E2});
        chk("t6_dst", 32'(last_dst), 32'h0809);
        chk("t6_done", 32'(done_cnt - b_done), 32'd1);
        chk("t6_err", 32'(err_cnt - b_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
